// File: rtl/guitar_lane_scorer_if.sv
// Lane/pixel bus between the note-lane blocks, the VGA sync stage and the
// scorer. The game controller sees it through the slave modport; whatever
// drives the lanes and consumes the pixel uses the master modport.
interface guitar_lane_scorer_if #(
    parameter int N_LANES = 4,
    parameter int SCORE_W = 16
);
    // Stimulus towards the scorer
    logic                   start;
    logic                   bright;
    logic [9:0]             hCount;
    logic [9:0]             vCount;
    logic [2*N_LANES-1:0]   lane_flag;
    logic [N_LANES-1:0]     lane_hit;
    logic [N_LANES-1:0]     lane_miss;
    logic [N_LANES-1:0]     lane_gone;
    logic                   gameover_in;
    logic [11:0]            title_rgb;
    logic [11:0]            gover_rgb;

    // Results from the scorer
    logic [11:0]            rgb;
    logic [SCORE_W-1:0]     score;
    logic [7:0]             combo;
    logic [7:0]             misses;
    logic [2:0]             mult;
    logic [49:0]            speed_shift;
    logic [1:0]             gamestate;

    modport master (
        output start, bright, hCount, vCount, lane_flag, lane_hit, lane_miss,
               lane_gone, gameover_in, title_rgb, gover_rgb,
        input  rgb, score, combo, misses, mult, speed_shift, gamestate
    );

    modport slave (
        input  start, bright, hCount, vCount, lane_flag, lane_hit, lane_miss,
               lane_gone, gameover_in, title_rgb, gover_rgb,
        output rgb, score, combo, misses, mult, speed_shift, gamestate
    );
endinterface

// File: rtl/guitar_lane_scorer.sv
// Game controller for the guitar-hero VGA design: game-state FSM, combo
// multiplier, miss limit, saturating score, speed output for the block movers
// and the registered pixel mux feeding the VGA output stage.
module guitar_lane_scorer #(
    parameter int N_LANES    = 4,
    parameter int SCORE_W    = 16,
    parameter int COMBO_STEP = 8,
    parameter int MAX_MULT   = 4,
    parameter int MAX_MISSES = 10,
    parameter int SPEED_STEP = 1000,
    parameter int SPEED_CAP  = 200000,
    parameter int ZONE_H0    = 144,
    parameter int ZONE_H1    = 784,
    parameter int ZONE_V0    = 400,
    parameter int ZONE_V1    = 455,
    // lane i colour lives at [12i+11:12i]: lane0 red, lane1 blue, lane2 yellow, lane3 pink
    parameter logic [12*N_LANES-1:0] LANE_COLORS = {12'hF6B, 12'hFF0, 12'h00F, 12'hF00}
) (
    input  logic                 clk,
    input  logic                 resetbtn,
    guitar_lane_scorer_if.slave  bus
);
    localparam logic [1:0] S_NONE  = 2'b00;
    localparam logic [1:0] S_TITLE = 2'b01;
    localparam logic [1:0] S_PLAY  = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    // Headroom for score + hits*mult before saturation
    localparam int SUM_W = SCORE_W + 8;
    localparam logic [SUM_W-1:0] SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});
    localparam logic [7:0]       MISS_LIM   = 8'(MAX_MISSES);
    localparam logic [7:0]       MULT_TOP   = 8'(MAX_MULT - 1);
    localparam logic [49:0]      SPEED_K    = 50'(SPEED_STEP);
    localparam logic [49:0]      SPEED_TOP  = 50'(SPEED_CAP);
    localparam logic [9:0]       H0 = 10'(ZONE_H0);
    localparam logic [9:0]       H1 = 10'(ZONE_H1);
    localparam logic [9:0]       V0 = 10'(ZONE_V0);
    localparam logic [9:0]       V1 = 10'(ZONE_V1);

    logic [1:0]             r_state, w_state_next;
    logic [SCORE_W-1:0]     r_score, w_score_next;
    logic [7:0]             r_combo, w_combo_next;
    logic [7:0]             r_misses, w_misses_next;
    logic [49:0]            r_speed, w_speed_next;
    logic [11:0]            r_rgb, w_rgb_next;

    logic [3:0]             w_hits, w_nmiss;
    logic [7:0]             w_combo_div;
    logic [2:0]             w_mult;
    logic [SUM_W-1:0]       w_score_sum;
    logic [SCORE_W-1:0]     w_score_sat;
    logic [8:0]             w_combo_sum, w_misses_sum;
    logic [7:0]             w_combo_upd, w_misses_upd;
    logic [49:0]            w_speed_prod;
    logic                   w_in_zone;
    logic [N_LANES-1:0]     w_lane_on;
    logic [12*N_LANES-1:0]  w_lane_rgb;
    logic [11:0]            w_play_rgb;

    // Count simultaneous hit and miss pulses across all lanes
    always_comb begin
        w_hits  = 4'd0;
        w_nmiss = 4'd0;
        for (int i = 0; i < N_LANES; i++) begin
            w_hits  = w_hits  + 4'(bus.lane_hit[i]);
            w_nmiss = w_nmiss + 4'(bus.lane_miss[i]);
        end
    end

    // Multiplier from the pre-update combo, clamped to MAX_MULT
    always_comb begin
        w_combo_div = 8'(r_combo / COMBO_STEP);
        if (w_combo_div >= MULT_TOP)
            w_mult = 3'(MAX_MULT);
        else
            w_mult = 3'(w_combo_div) + 3'd1;
    end

    // Saturating candidate values for the counters
    always_comb begin
        w_score_sum  = SUM_W'(r_score) + SUM_W'(w_hits) * SUM_W'(w_mult);
        w_score_sat  = (w_score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
        w_combo_sum  = {1'b0, r_combo} + 9'(w_hits);
        w_misses_sum = {1'b0, r_misses} + 9'(w_nmiss);
        // a miss in the same cycle as hits still breaks the streak
        if (w_nmiss != 4'd0)
            w_combo_upd = 8'd0;
        else
            w_combo_upd = w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
        w_misses_upd = w_misses_sum[8] ? 8'hFF : w_misses_sum[7:0];
    end

    // Game-state transitions and counter updates (counters move only in PLAY)
    always_comb begin
        w_state_next  = r_state;
        w_score_next  = r_score;
        w_combo_next  = r_combo;
        w_misses_next = r_misses;
        case (r_state)
            S_TITLE: begin
                if (bus.start) begin
                    w_state_next  = S_PLAY;
                    w_score_next  = '0;
                    w_combo_next  = 8'd0;
                    w_misses_next = 8'd0;
                end
            end
            S_PLAY: begin
                w_score_next  = w_score_sat;
                w_combo_next  = w_combo_upd;
                w_misses_next = w_misses_upd;
                // end-of-game conditions take precedence over the abort
                if (bus.gameover_in || (&bus.lane_gone) || (w_misses_upd >= MISS_LIM))
                    w_state_next = S_OVER;
                else if (!bus.start)
                    w_state_next = S_TITLE;
            end
            S_OVER: begin
                if (!bus.start)
                    w_state_next = S_TITLE;
            end
            S_NONE:  w_state_next = S_TITLE;
            default: w_state_next = S_TITLE;
        endcase
    end

    // Speed follows the registered score, capped
    always_comb begin
        w_speed_prod = 50'(r_score) * SPEED_K;
        w_speed_next = (w_speed_prod > SPEED_TOP) ? SPEED_TOP : w_speed_prod;
    end

    // Per-lane colour decode of the 2-bit pixel flags
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        assign w_lane_on[gi] = |bus.lane_flag[2*gi +: 2];
        assign w_lane_rgb[12*gi +: 12] =
            (bus.lane_flag[2*gi +: 2] == 2'b01) ? LANE_COLORS[12*gi +: 12] :
            (bus.lane_flag[2*gi +: 2] == 2'b10) ? 12'h0F0 :
            (bus.lane_flag[2*gi +: 2] == 2'b11) ? 12'hF20 : 12'h000;
    end

    assign w_in_zone = (bus.hCount >= H0) && (bus.hCount <= H1) &&
                       (bus.vCount >= V0) && (bus.vCount <= V1);

    // Play-field pixel: lowest-index flagged lane wins, else strike zone
    always_comb begin
        w_play_rgb = w_in_zone ? 12'hFFF : 12'h000;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (w_lane_on[i])
                w_play_rgb = w_lane_rgb[12*i +: 12];
        end
    end

    // Screen source selection by game state, blanked outside display area
    always_comb begin
        w_rgb_next = 12'h000;
        if (bus.bright) begin
            case (r_state)
                S_TITLE: w_rgb_next = bus.title_rgb;
                S_PLAY:  w_rgb_next = w_play_rgb;
                S_OVER:  w_rgb_next = bus.gover_rgb;
                default: w_rgb_next = 12'h000;
            endcase
        end
    end

    // State, counters, speed and pixel registers
    always_ff @(posedge clk) begin
        if (resetbtn) begin
            r_state  <= S_TITLE;
            r_score  <= '0;
            r_combo  <= 8'd0;
            r_misses <= 8'd0;
            r_speed  <= 50'd0;
            r_rgb    <= 12'h000;
        end else begin
            r_state  <= w_state_next;
            r_score  <= w_score_next;
            r_combo  <= w_combo_next;
            r_misses <= w_misses_next;
            r_speed  <= w_speed_next;
            r_rgb    <= w_rgb_next;
        end
    end

    assign bus.rgb         = r_rgb;
    assign bus.score       = r_score;
    assign bus.combo       = r_combo;
    assign bus.misses      = r_misses;
    assign bus.mult        = w_mult;
    assign bus.speed_shift = r_speed;
    assign bus.gamestate   = r_state;
endmodule
